// File: rtl/lcd_16207_cmd_sequencer_if.sv
// Command and Avalon-MM bus bundle for the LCD 16207 command sequencer.
//
// Handshake: a request (cmd_rs, cmd_data) is transferred on the rising clock
// edge where cmd_valid && cmd_ready are both high. cmd_ready never depends on
// cmd_valid. A source that sees cmd_ready low must keep cmd_valid and its
// payload stable until the transfer edge; nothing is queued while not ready.
interface lcd_16207_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       busy;
  logic       init_done;
  logic [1:0] av_address;
  logic       av_write;
  logic       av_read;
  logic       av_begintransfer;
  logic [7:0] av_writedata;
  logic [2:0] state_dbg;

  // Command source / bus observer side
  modport master (
    output cmd_valid, cmd_rs, cmd_data,
    input  cmd_ready, busy, init_done, av_address, av_write, av_read,
           av_begintransfer, av_writedata, state_dbg
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_rs, cmd_data,
    output cmd_ready, busy, init_done, av_address, av_write, av_read,
           av_begintransfer, av_writedata, state_dbg
  );
endinterface

// File: rtl/lcd_16207_cmd_sequencer.sv
// LCD 16207 command sequencer: Avalon-MM write master that turns byte requests
// into address-setup / E-pulse / hold / execution-wait sequences for an
// HD44780-style panel. av_write drives LCD_E directly, so all timing is shaped here.
// Optional power-on initialisation ROM is enabled with `define LCD_SEQ_INIT_EN.
module lcd_16207_cmd_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int E_CYC          = 13,
  parameter int HOLD_CYC       = 1,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int POWERON_CYC    = 750000,
  parameter int CNT_W          = 20
) (
  input logic                       clk,
  input logic                       reset,
  lcd_16207_cmd_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_STROBE    = 3'd2,
    S_HOLD      = 3'd3,
    S_WAIT      = 3'd4,
    S_INIT_WAIT = 3'd5
  } state_t;

  // Counter load values are "cycles - 1": the state ends when the counter hits 0.
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD       = CNT_W'(E_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] POWERON_LD = CNT_W'(POWERON_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_WAIT = CNT_W'(SHORT_WAIT_CYC);
  localparam logic [CNT_W-1:0] LONG_WAIT  = CNT_W'(LONG_WAIT_CYC);

`ifdef LCD_SEQ_INIT_EN
  localparam state_t RESET_STATE = S_INIT_WAIT;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             init_done;
  logic             ready;
  logic             accept;

`ifdef LCD_SEQ_INIT_EN
  logic [2:0] rom_idx, rom_idx_d;
  logic       init_done_q, init_done_d;

  // Function set 8-bit/2-line (x3), display on, clear, entry mode increment.
  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: rom_byte = 8'h38;
      3'd3:             rom_byte = 8'h0C;
      3'd4:             rom_byte = 8'h01;
      default:          rom_byte = 8'h06;
    endcase
  endfunction

  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
  function automatic logic [CNT_W-1:0] wait_sel(input logic rs, input logic [7:0] data);
    wait_sel = (!rs && (data[7:1] == 7'h00 || data[7:1] == 7'h01)) ? LONG_WAIT : SHORT_WAIT;
  endfunction

  assign ready  = (state == S_IDLE) && init_done;
  assign accept = bus.cmd_valid && ready;

  // Next-state, counter and latched-command logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wait_d  = wait_q;
    rs_d    = rs_q;
    data_d  = data_q;
`ifdef LCD_SEQ_INIT_EN
    rom_idx_d   = rom_idx;
    init_done_d = init_done_q;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          rs_d    = bus.cmd_rs;
          data_d  = bus.cmd_data;
          wait_d  = wait_sel(bus.cmd_rs, bus.cmd_data);
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_d = S_STROBE;
          cnt_d   = E_LD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_d = S_WAIT;
          cnt_d   = wait_q - 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
`ifdef LCD_SEQ_INIT_EN
          if (!init_done_q && rom_idx != 3'd5) begin
            rom_idx_d = rom_idx + 3'd1;
            rs_d      = 1'b0;
            data_d    = rom_byte(rom_idx + 3'd1);
            wait_d    = LONG_WAIT;
            state_d   = S_SETUP;
            cnt_d     = SETUP_LD;
          end else begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
`ifdef LCD_SEQ_INIT_EN
      S_INIT_WAIT: begin
        if (cnt == '0) begin
          rom_idx_d = 3'd0;
          rs_d      = 1'b0;
          data_d    = rom_byte(3'd0);
          wait_d    = CNT_W'(POWERON_CYC);
          state_d   = S_SETUP;
          cnt_d     = SETUP_LD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; the counter preloads the power-on wait
  // (only meaningful when the init ROM is built in).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RESET_STATE;
      cnt    <= POWERON_LD;
      wait_q <= '0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
`ifdef LCD_SEQ_INIT_EN
      rom_idx     <= 3'd0;
      init_done_q <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      wait_q <= wait_d;
      rs_q   <= rs_d;
      data_q <= data_d;
`ifdef LCD_SEQ_INIT_EN
      rom_idx     <= rom_idx_d;
      init_done_q <= init_done_d;
`endif
    end
  end

  // Outputs decode the asynchronously reset state, so E drops the moment reset rises.
  assign bus.cmd_ready        = ready;
  assign bus.busy             = (state != S_IDLE);
  assign bus.init_done        = init_done;
  assign bus.av_address       = {rs_q, 1'b0};
  assign bus.av_writedata     = data_q;
  assign bus.av_write         = (state == S_STROBE);
  assign bus.av_read          = 1'b0;
  assign bus.av_begintransfer = (state == S_STROBE) && (cnt == E_LD);
  assign bus.state_dbg        = state;

endmodule

// File: tb/tb_lcd_16207_cmd_sequencer.sv
// Self-checking bench for lcd_16207_cmd_sequencer (define LCD_SEQ_INIT_EN to
// exercise the power-on ROM build).
module tb_lcd_16207_cmd_sequencer;

  localparam int SETUP   = 2;
  localparam int E       = 4;
  localparam int HOLD    = 1;
  localparam int SHORT   = 10;
  localparam int LONG    = 50;
  localparam int POWERON = 100;
  localparam int LIMIT   = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  lcd_16207_cmd_sequencer_if bus ();

  lcd_16207_cmd_sequencer #(
    .SETUP_CYC(SETUP), .E_CYC(E), .HOLD_CYC(HOLD), .SHORT_WAIT_CYC(SHORT),
    .LONG_WAIT_CYC(LONG), .POWERON_CYC(POWERON), .CNT_W(20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: execution wait chosen from the command byte alone.
  function automatic int exp_wait(input logic rs, input logic [7:0] d);
    return (!rs && d <= 8'h03) ? LONG : SHORT;
  endfunction

  // Present a request at a negedge and return after its accept edge.
  task automatic issue(input logic rs, input logic [7:0] d, output int waited);
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = rs;
    bus.cmd_data  = d;
    waited = 0;
    while (!bus.cmd_ready && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
  endtask

  // Check every cycle of one transaction following its accept edge.
  task automatic track_txn(input logic rs, input logic [7:0] d, input logic hold,
                           input logic nrs, input logic [7:0] nd);
    int period;
    period = 1 + SETUP + E + HOLD + exp_wait(rs, d);
    for (int k = 1; k <= period; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          bus.cmd_rs   = nrs;
          bus.cmd_data = nd;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      check("av_write", bus.av_write, (k > SETUP) && (k <= SETUP + E));
      check("begintransfer", bus.av_begintransfer, k == SETUP + 1);
      check("av_address", bus.av_address, {rs, 1'b0});
      check("av_writedata", bus.av_writedata, d);
      check("cmd_ready", bus.cmd_ready, k == period);
      check("busy", bus.busy, k != period);
      check("av_read", bus.av_read, 1'b0);
    end
  endtask

  // Watch the power-on sequence from reset release until init_done.
  task automatic init_check();
    logic [7:0] exp_q[$];
    int c, width, since_fall, pulses;
    logic prev_w, seen_done;
    exp_q = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    c = 0; width = 0; since_fall = -1; pulses = 0;
    prev_w = 1'b0; seen_done = 1'b0;
    bus.cmd_valid = 1'b1;
    while (!seen_done && c < LIMIT) begin
      @(negedge clk);
      c++;
      bus.cmd_rs   = 1'($urandom_range(0, 1));
      bus.cmd_data = 8'($urandom);
      if (bus.av_write && !prev_w) begin
        pulses++;
        check("init_quiet", c > POWERON, 1'b1);
        check("init_addr", bus.av_address, 2'b00);
        if (exp_q.size() > 0) check("init_byte", bus.av_writedata, exp_q.pop_front());
        else check("init_extra_pulse", pulses, 6);
        width = 0;
        since_fall = -1;
      end
      if (bus.av_write) width++;
      if (!bus.av_write && prev_w) begin
        check("init_e_width", width, E);
        since_fall = 0;
      end
      if (since_fall >= 0) since_fall++;
      if (bus.init_done) begin
        seen_done = 1'b1;
        bus.cmd_valid = 1'b0;
        check("init_done_delay", since_fall, HOLD + LONG + 1);
        check("init_pulse_count", pulses, 6);
        check("init_ready", bus.cmd_ready, 1'b1);
      end else begin
        check("init_not_ready", bus.cmd_ready, 1'b0);
      end
      prev_w = bus.av_write;
    end
    bus.cmd_valid = 1'b0;
    check("init_done_seen", seen_done, 1'b1);
  endtask

  initial begin
    int w;
    logic r_rs;
    logic [7:0] r_d;
    bus.cmd_valid = 1'b0;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h00;

    // Reset block
    repeat (3) @(negedge clk);
    check("rst_av_write", bus.av_write, 1'b0);
    check("rst_av_address", bus.av_address, 2'b00);
    check("rst_av_writedata", bus.av_writedata, 8'h00);
    check("rst_begintransfer", bus.av_begintransfer, 1'b0);
    check("rst_av_read", bus.av_read, 1'b0);
`ifdef LCD_SEQ_INIT_EN
    check("rst_init_done", bus.init_done, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    reset = 1'b0;
    init_check();
`else
    check("rst_busy", bus.busy, 1'b0);
    check("rst_init_done", bus.init_done, 1'b1);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);
`endif

    // Character write, clear/home long waits, ordinary short waits
    issue(1'b1, 8'h41, w); track_txn(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    issue(1'b0, 8'h01, w); track_txn(1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
    issue(1'b0, 8'h03, w); track_txn(1'b0, 8'h03, 1'b0, 1'b0, 8'h00);
    issue(1'b0, 8'h80, w); track_txn(1'b0, 8'h80, 1'b0, 1'b0, 8'h00);
    issue(1'b1, 8'h00, w); track_txn(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);

    // Back-to-back with cmd_valid held high throughout
    issue(1'b1, 8'h41, w); track_txn(1'b1, 8'h41, 1'b1, 1'b1, 8'h42);
    issue(1'b1, 8'h42, w); check("b2b_accept_2", w, 0);
    track_txn(1'b1, 8'h42, 1'b1, 1'b1, 8'h43);
    issue(1'b1, 8'h43, w); check("b2b_accept_3", w, 0);
    track_txn(1'b1, 8'h43, 1'b0, 1'b0, 8'h00);

    // Randomized commands, biased toward the clear/home boundary
    for (int i = 0; i < 20; i++) begin
      r_rs = 1'($urandom_range(0, 1));
      r_d  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(r_rs, r_d, w);
      track_txn(r_rs, r_d, 1'b0, 1'b0, 8'h00);
    end

    // Asynchronous reset in the middle of the E pulse
    issue(1'b1, 8'h55, w);
    for (int k = 1; k <= SETUP + 2; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
    end
    check("mid_strobe_write", bus.av_write, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_write_drop", bus.av_write, 1'b0);
    check("async_begin_drop", bus.av_begintransfer, 1'b0);
    @(negedge clk);
    reset = 1'b0;
`ifdef LCD_SEQ_INIT_EN
    init_check();
`else
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check("post_rst_no_write", bus.av_write, 1'b0);
      check("post_rst_ready", bus.cmd_ready, 1'b1);
      check("post_rst_busy", bus.busy, 1'b0);
    end
`endif
    issue(1'b1, 8'h5A, w); track_txn(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
